// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared states and constants for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] LOADER_HDR        = 8'hA5;
    localparam int         LOADER_WORD_BYTES = 4;

    // A broken frame only matters once a load is in progress.
    function automatic logic frame_err_fatal(input loader_state_t s);
        return !(s inside {IDLE, DONE, ERROR});
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receive deserializer with start-bit glitch rejection.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_t        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             bv_q, bv_d;
    logic             fe_q, fe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            bv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            bv_q    <= bv_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        unique case (st_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    st_d  = RX_START;
                    cnt_d = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid-start-bit was only a glitch.
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        st_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    st_d  = RX_IDLE;
                    if (sync2_q) begin
                        bv_d   = 1'b1;
                        data_d = shift_q;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    assign byte_valid = bv_q;
    assign byte_data  = data_q;
    assign frame_err  = fe_q;

endmodule

// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - UART boot loader writing an image into instruction memory.
// Define LOADER_CHECKSUM_EN to verify the trailing XOR checksum byte.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int IMEM_WORDS = 1024,
    parameter int ADDR_W     = $clog2(IMEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              im_wen,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [16:0] MAX_WORDS    = 17'(IMEM_WORDS);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    loader_state_t     state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       word_q, word_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, done_q, err_q;
    logic [15:0]       n_len;
    logic              csum_ok;

    assign n_len = {byte_data, len_lo_q};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum_ok = (byte_data == csum_q);
`else
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            wcnt_q   <= wcnt_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            hold_q   <= (state_d != DONE);
            done_q   <= (state_d == DONE);
            err_q    <= (state_d == ERROR);
        end
    end

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (byte_valid && byte_data == LOADER_HDR) begin
                    state_d = LEN_LO;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LEN_LO: begin
                if (byte_valid) begin
                    len_lo_d = byte_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (byte_valid) begin
                    len_d = n_len;
                    if ({1'b0, n_len} > MAX_WORDS) begin
                        state_d = ERROR;
                    end else if (n_len == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // Leave only after the final strobe so im_wen never fires outside DATA.
                if (wen_q && wcnt_q == len_q) begin
                    state_d = CSUM;
                end else if (byte_valid) begin
                    word_d = {byte_data, word_q[31:8]};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    if (bcnt_q == 2'(LOADER_WORD_BYTES - 1)) begin
                        wen_d   = 1'b1;
                        waddr_d = wcnt_q[ADDR_W-1:0];
                        wdata_d = {byte_data, word_q[31:8]};
                        wcnt_d  = wcnt_q + 16'd1;
                    end
                end
            end
            CSUM: begin
                if (byte_valid) begin
                    state_d = csum_ok ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
        if (frame_err && frame_err_fatal(state_q)) begin
            state_d = ERROR;
        end
    end

    assign im_wen    = wen_q;
    assign im_waddr  = waddr_q;
    assign im_wdata  = wdata_q;
    assign core_hold = hold_q;
    assign done      = done_q;
    assign error     = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - self-checking bench for uart_imem_loader.
module tb_uart_imem_loader;

    localparam int CLK_HZ     = 1600;
    localparam int BAUD       = 100;
    localparam int CPB        = CLK_HZ / BAUD;
    localparam int IMEM_WORDS = 1024;
    localparam int ADDR_W     = 10;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              uart_rx = 1'b1;
    logic              im_wen;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;
    logic              core_hold, done, error;

    always #5 clk = ~clk;

    uart_imem_loader #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .IMEM_WORDS(IMEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .im_wen   (im_wen),
        .im_waddr (im_waddr),
        .im_wdata (im_wdata),
        .core_hold(core_hold),
        .done     (done),
        .error    (error)
    );

    int          tests = 0;
    int          fails = 0;
    int          bv_cnt = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] mw [4];

    always @(negedge clk) begin
        if (im_wen) begin
            wa_q.push_back(32'(im_waddr));
            wd_q.push_back(im_wdata);
        end
        if (dut.u_rx.byte_valid) bv_cnt++;
    end

    typedef struct {
        string       name;
        int          first;
        int          nb;
        bit          e_done;
        bit          e_err;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t       vt [5];
    logic [7:0] stim [37];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
    endtask

    // Reference framing: header, little-endian count, payload words LSB first, XOR byte.
    task automatic send_load(input int n, input bit bad);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [15:0] n16;
        x   = 8'h00;
        n16 = 16'(n);
        send_byte(8'hA5, 1'b1);
        send_byte(n16[7:0], 1'b1);
        send_byte(n16[15:8], 1'b1);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = mw[w][8*k +: 8];
                x = x ^ b;
                send_byte(b, 1'b1);
            end
        end
        send_byte(bad ? (x ^ 8'h5A) : x, 1'b1);
    endtask

    initial begin
        stim = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90,
                 8'h55, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08,
                 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09,
                 8'hA5, 8'h01, 8'h04,
                 8'hA5, 8'h00, 8'h00, 8'h00};
        vt[0] = '{"basic",    0, 12, 1'b1,   1'b0,  2, 32'h00000013, 32'h00100093};
        vt[1] = '{"noise",   12, 10, 1'b1,   1'b0,  1, 32'h12345678, 32'h0};
        vt[2] = '{"bad_csum", 22, 8, !CK_EN, CK_EN, 1, 32'h12345678, 32'h0};
        vt[3] = '{"too_long", 30, 3, 1'b0,   1'b1,  0, 32'h0,        32'h0};
        vt[4] = '{"zero_len", 33, 4, 1'b1,   1'b0,  0, 32'h0,        32'h0};

        do_reset();
        check("rst_wen",   32'(im_wen),    32'd0);
        check("rst_waddr", 32'(im_waddr),  32'd0);
        check("rst_wdata", im_wdata,       32'd0);
        check("rst_hold",  32'(core_hold), 32'd1);
        check("rst_done",  32'(done),      32'd0);
        check("rst_error", 32'(error),     32'd0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            clear_writes();
            for (int j = 0; j < vt[i].nb; j++) send_byte(stim[vt[i].first + j], 1'b1);
            repeat (4) @(negedge clk);
            check({vt[i].name, "_done"},   32'(done),        32'(vt[i].e_done));
            check({vt[i].name, "_error"},  32'(error),       32'(vt[i].e_err));
            check({vt[i].name, "_hold"},   32'(core_hold),   32'(!vt[i].e_done));
            check({vt[i].name, "_nwr"},    32'(wa_q.size()), 32'(vt[i].nw));
            if (vt[i].nw > 0 && wa_q.size() > 0) begin
                check({vt[i].name, "_a0"}, wa_q[0], 32'd0);
                check({vt[i].name, "_d0"}, wd_q[0], vt[i].w0);
            end
            if (vt[i].nw > 1 && wa_q.size() > 1) begin
                check({vt[i].name, "_a1"}, wa_q[1], 32'd1);
                check({vt[i].name, "_d1"}, wd_q[1], vt[i].w1);
            end
        end

        // Reset in the middle of a word, then a fresh load.
        do_reset();
        clear_writes();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        do_reset();
        check("midrst_nowr", 32'(wa_q.size()), 32'd0);
        mw[0] = 32'hCAFEF00D;
        mw[1] = 32'h0BADBEEF;
        send_load(2, 1'b0);
        repeat (4) @(negedge clk);
        check("midrst_nwr",  32'(wa_q.size()), 32'd2);
        if (wa_q.size() > 0) begin
            check("midrst_a0", wa_q[0], 32'd0);
            check("midrst_d0", wd_q[0], 32'hCAFEF00D);
        end
        check("midrst_done", 32'(done), 32'd1);

        // Quarter-bit glitch on the idle line while DONE.
        bv_cnt = 0;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_bv",   32'(bv_cnt),    32'd0);
        check("glitch_done", 32'(done),      32'd1);
        check("glitch_hold", 32'(core_hold), 32'd0);

        // Reload from DONE: header alone must re-assert hold and clear done.
        send_byte(8'hA5, 1'b1);
        check("reload_done",  32'(done),      32'd0);
        check("reload_hold",  32'(core_hold), 32'd1);
        check("reload_error", 32'(error),     32'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        check("reload_fin", 32'(done), 32'd1);

        // Framing error inside a payload.
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (4) @(negedge clk);
        check("ferr_data_err",  32'(error), 32'd1);
        check("ferr_data_done", 32'(done),  32'd0);

        // Framing error while idle is ignored, including the header it corrupts.
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        check("ferr_idle_err",  32'(error),     32'd0);
        check("ferr_idle_hold", 32'(core_hold), 32'd1);

        // Randomized back-to-back loads checked against the framing model.
        do_reset();
        for (int it = 0; it < 6; it++) begin
            int n;
            bit bad;
            bit ok;
            n   = $urandom_range(0, 4);
            bad = ($urandom_range(0, 3) == 0);
            ok  = !(bad && CK_EN);
            for (int w = 0; w < 4; w++) mw[w] = $urandom;
            clear_writes();
            send_load(n, bad);
            repeat (4) @(negedge clk);
            check("rnd_done",  32'(done),        32'(ok));
            check("rnd_error", 32'(error),       32'(!ok));
            check("rnd_hold",  32'(core_hold),   32'(!ok));
            check("rnd_nwr",   32'(wa_q.size()), 32'(n));
            for (int w = 0; w < n && w < wa_q.size(); w++) begin
                check("rnd_addr", wa_q[w], 32'(w));
                check("rnd_data", wd_q[w], mw[w]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
